serial_to_parallel_stream: RTL
==============================

Name: serial_to_parallel_stream

Overview:
- Generalised deserialiser. Packs in_width-bit beats into out_width-bit words.
- Full ready/valid handshake on both sides, so the downstream consumer can stall it.
- Selectable beat ordering (first beat in LSBs or in MSBs).
- Flush sideband emits a partial word together with a beat count.
- Sits between narrow serial front-ends and wide datapath consumers. Default parameters give the classic 1-bit to 8-bit LSB-first deserialiser.

Parameters:
- in_width, 1: bits per input beat.
- out_width, 8: bits per output word. Must be an integer multiple of in_width, ≥ 2*in_width.
- msb_first, 0: 0 = first beat lands in out_data[in_width-1:0]; 1 = first beat lands in out_data[out_width-1 -: in_width].
- Derived, not overridable: beats = out_width/in_width; cw = $clog2(beats+1).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat and/or flush this cycle
- in_data  input  in_width  input beat
- flush  input  1  close the current word early; qualified by in_ready
- out_valid  output  1  output word valid
- out_ready  input  1  consumer accepts word
- out_data  output  out_width  assembled word
- out_count  output  cw  number of valid beats in out_data (beats = full word)

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, out_data=0, out_count=0. Beat counter cnt=0, accumulator cleared. Any partial word is discarded. in_ready=1 in the cycle after reset releases. Reset overrides every other input.
- Internal state:
  - Accumulator register and cnt (0..beats-1).
  - One output holding register carrying out_data, out_count and out_valid.
  - A full word therefore has 1 cycle latency from its last accepted beat to out_valid.
- slot_free = !out_valid || out_ready.
- in_ready is combinational, no combinational path from in_valid:
  - flush=1: in_ready = slot_free.
  - flush=0 and cnt==beats-1: in_ready = slot_free.
  - otherwise: in_ready = 1.
- Beat accepted when in_valid && in_ready. It is written at position cnt: bits [cnt*in_width +: in_width] if msb_first=0, [(beats-1-cnt)*in_width +: in_width] if msb_first=1.
- Word completion: accepted beat with cnt==beats-1.
  - Next cycle: out_valid=1, out_count=beats, out_data = full word.
  - cnt returns to 0 and the accumulator clears.
- Flush taken when flush && in_ready. Let n = cnt + (beat accepted this cycle ? 1 : 0).
  - If n>0: out_data = accumulator including that beat, with unfilled positions zero. out_count=n, out_valid=1 next cycle, cnt→0.
  - If n==0: no-op, no output generated.
  - If the beat completes a word in the same cycle as flush, the result is a normal full word (out_count=beats).
- Output hold: while out_valid && !out_ready, out_data and out_count stay stable and out_valid stays high.
- Drain: out_valid && out_ready with no new word → out_valid=0 next cycle. out_data and out_count hold their last values.
- Back-to-back: out_ready held high plus a continuous in_valid stream gives one word every beats cycles, with no bubbles.
- Simultaneous drain and load: the new word replaces the old one in the same edge, and out_valid stays 1.
- Accumulation continues under backpressure. Only the completing beat (or a flush) stalls.
- in_data is ignored when in_valid=0. flush without in_ready has no effect, and the source must hold flush.

Test Plan:
- Defaults (1→8, LSB-first): serial bits 1,0,1,1,0,0,1,0 with in_valid every cycle and out_ready=1 → one cycle after the 8th bit, out_valid=1 for 1 cycle, out_data=8'h4D, out_count=8.
- in_width=2, out_width=8, msb_first=0: beats 01,10,11,00 → out_data=8'h39, out_count=4. Same stimulus with msb_first=1 → out_data=8'h6C.
- in_width=2, out_width=8, msb_first=1: beats 01,10,11, then flush with in_valid=0 → out_data=8'h6C, out_count=3. Flush with cnt==0 and in_valid=0 → out_valid stays 0.
- Backpressure, 2→8, out_ready=0, 8 beats offered:
  - Word 1 held stable; beats 5-7 are accepted.
  - On beat 8, in_ready=0 while out_valid=1.
  - Raise out_ready: beat 8 is accepted that cycle and word 2 appears next cycle with out_valid continuously 1.
  - No beat lost or duplicated.
- Interleave in_valid gaps (random 50% duty), 1→8 → words identical to the gapless case; out_valid pulses only on completion.
- Assert rst after 3 of 8 bits → outputs 0. The next 8 bits form a clean word, and the pre-reset bits never appear.

Source files
------------

// File: rtl/serial_to_parallel_stream.sv
`default_nettype none
// ============================================================================
// Module   : serial_to_parallel_stream
// Brief    : Ready/valid deserialiser packing IN_WIDTH-bit beats into
//            OUT_WIDTH-bit words, with selectable beat order and early flush.
// Revision : 1.0 - initial release
// ============================================================================
module serial_to_parallel_stream #(
    parameter  int IN_WIDTH  = 1,
    parameter  int OUT_WIDTH = 8,
    parameter  int MSB_FIRST = 0,
    localparam int c_BEATS   = OUT_WIDTH / IN_WIDTH,
    localparam int c_CW      = $clog2(c_BEATS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [c_CW-1:0]      out_count
);

    logic [c_CW-1:0]      r_cnt;
    logic [OUT_WIDTH-1:0] r_acc;
    logic                 r_out_valid;
    logic [OUT_WIDTH-1:0] r_out_data;
    logic [c_CW-1:0]      r_out_count;

    logic                 w_slot_free;
    logic                 w_last;
    logic                 w_accept;
    logic                 w_flush;
    logic                 w_load;
    logic [c_CW-1:0]      w_pos;
    logic [c_CW-1:0]      w_n;
    logic [OUT_WIDTH-1:0] w_beat;
    logic [OUT_WIDTH-1:0] w_acc_ins;

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_last      = (r_cnt == c_CW'(c_BEATS - 1));

    // Only a beat or flush that would load the holding register can stall.
    assign in_ready    = (flush || w_last) ? w_slot_free : 1'b1;

    assign w_accept    = in_valid && in_ready;
    assign w_flush     = flush && in_ready;

    assign w_pos       = (MSB_FIRST != 0) ? (c_CW'(c_BEATS - 1) - r_cnt) : r_cnt;
    assign w_beat      = OUT_WIDTH'(in_data) << (int'(w_pos) * IN_WIDTH);
    // Unfilled slots of the accumulator are always zero, so OR-in is enough.
    assign w_acc_ins   = w_accept ? (r_acc | w_beat) : r_acc;
    assign w_n         = r_cnt + c_CW'(w_accept);
    assign w_load      = (w_accept && w_last) || (w_flush && (w_n != '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_acc_ins;
            r_out_count <= w_n;
            r_cnt       <= '0;
            r_acc       <= '0;
        end else begin
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_acc <= w_acc_ins;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;

endmodule
`default_nettype wire
